// File: rtl/seq_magnitude_comparator.sv
// Time-serial magnitude comparator: walks the latched operands MSB-first, SLICE bits
// per clock, and reports eq/gt/lt through registered flags with a start/busy/done handshake.
//
// state      | meaning
// STATE_IDLE | waiting for start; result flags hold the last outcome
// STATE_RUN  | comparing one slice per clock, index counting down to 0
module seq_magnitude_comparator #(
    parameter int WIDTH      = 8,
    parameter int SLICE      = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             msb_signed,
    output logic             busy,
    output logic             done,
    output logic             AeqB,
    output logic             AgtB,
    output logic             AltB
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if ((WIDTH < 2) || (SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : gBadParams
            $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of SLICE");
        end
    endgenerate

    logic [0:0]       state;
    logic [IDXW-1:0]  index;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic             stickyVld;
    logic             stickyGt;

    logic [31:0]      bitBase;
    logic [SLICE-1:0] sliceA;
    logic [SLICE-1:0] sliceB;
    logic             sliceDiff;
    logic             sliceGt;
    logic             lastSlice;
    logic             finishNow;
    logic             resEq;
    logic             resGt;

    assign bitBase   = 32'(index) * SLICE;
    assign sliceA    = regA[bitBase +: SLICE];
    assign sliceB    = regB[bitBase +: SLICE];
    assign sliceDiff = (sliceA != sliceB);
    assign sliceGt   = (sliceA > sliceB);
    assign lastSlice = (index == '0);

    // Without early exit, the most significant difference seen so far wins at the last slice.
    always_comb begin
        finishNow = 1'b0;
        resEq     = 1'b0;
        resGt     = 1'b0;
        if (EARLY_EXIT != 0) begin
            if (sliceDiff) begin
                finishNow = 1'b1;
                resGt     = sliceGt;
            end else if (lastSlice) begin
                finishNow = 1'b1;
                resEq     = 1'b1;
            end
        end else if (lastSlice) begin
            finishNow = 1'b1;
            if (stickyVld) begin
                resGt = stickyGt;
            end else if (sliceDiff) begin
                resGt = sliceGt;
            end else begin
                resEq = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= STATE_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            AeqB      <= 1'b0;
            AgtB      <= 1'b0;
            AltB      <= 1'b0;
            index     <= '0;
            regA      <= '0;
            regB      <= '0;
            stickyVld <= 1'b0;
            stickyGt  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (start) begin
                        // Flipping the sign bits maps two's complement onto unsigned order.
                        regA      <= A ^ (msb_signed ? SIGN_MASK : '0);
                        regB      <= B ^ (msb_signed ? SIGN_MASK : '0);
                        index     <= IDXW'(NSLICE - 1);
                        stickyVld <= 1'b0;
                        stickyGt  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= STATE_RUN;
                    end
                end
                STATE_RUN: begin
                    if (finishNow) begin
                        AeqB  <= resEq;
                        AgtB  <= !resEq && resGt;
                        AltB  <= !resEq && !resGt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= STATE_IDLE;
                    end else begin
                        index <= index - IDXW'(1);
                        if (!stickyVld && sliceDiff) begin
                            stickyVld <= 1'b1;
                            stickyGt  <= sliceGt;
                        end
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: three parameterisations share one stimulus stream
// and are checked against an integer-arithmetic reference model.
module tb_seq_magnitude_comparator;

    localparam int NDUT = 3;
    localparam int WINDOW = 14;
    localparam int PW[NDUT] = '{8, 8, 16};
    localparam int PS[NDUT] = '{1, 1, 4};
    localparam int PE[NDUT] = '{1, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] opA = '0;
    logic [15:0] opB = '0;
    logic        sgn = 1'b0;

    logic bsy[NDUT];
    logic dn[NDUT];
    logic eq[NDUT];
    logic gt[NDUT];
    logic lt[NDUT];

    int checks = 0;
    int errors = 0;

    int          lat[NDUT];
    int          dnCnt[NDUT];
    logic [2:0]  fl[NDUT];
    logic [2:0]  prevFl[NDUT];
    int          busyCnt;
    int          chgCnt;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(8), .SLICE(1), .EARLY_EXIT(1)) u8e (
        .clk(clk), .rst_n(rst_n), .start(start), .A(opA[7:0]), .B(opB[7:0]),
        .msb_signed(sgn), .busy(bsy[0]), .done(dn[0]), .AeqB(eq[0]), .AgtB(gt[0]), .AltB(lt[0]));

    seq_magnitude_comparator #(.WIDTH(8), .SLICE(1), .EARLY_EXIT(0)) u8n (
        .clk(clk), .rst_n(rst_n), .start(start), .A(opA[7:0]), .B(opB[7:0]),
        .msb_signed(sgn), .busy(bsy[1]), .done(dn[1]), .AeqB(eq[1]), .AgtB(gt[1]), .AltB(lt[1]));

    seq_magnitude_comparator #(.WIDTH(16), .SLICE(4), .EARLY_EXIT(1)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(opA), .B(opB),
        .msb_signed(sgn), .busy(bsy[2]), .done(dn[2]), .AeqB(eq[2]), .AgtB(gt[2]), .AltB(lt[2]));

    function automatic logic [2:0] flagsOf(input int i);
        return {eq[i], gt[i], lt[i]};
    endfunction

    // {eq, gt, lt} from plain integer values of the operands.
    function automatic logic [2:0] refFlags(input logic [15:0] a, input logic [15:0] b,
                                            input int w, input logic sg);
        longint va, vb, mask;
        mask = (longint'(1) << w) - 1;
        va = longint'(a) & mask;
        vb = longint'(b) & mask;
        if (sg && va >= (longint'(1) << (w - 1))) va -= (longint'(1) << w);
        if (sg && vb >= (longint'(1) << (w - 1))) vb -= (longint'(1) << w);
        return {va == vb, va > vb, va < vb};
    endfunction

    // Edges from start to done: leading equal slices + 1, or all slices.
    function automatic int refLat(input logic [15:0] a, input logic [15:0] b,
                                  input int w, input int s, input int ee);
        longint m, va, vb;
        int n;
        n = w / s;
        if (ee == 0) return n;
        m = (longint'(1) << s) - 1;
        va = longint'(a);
        vb = longint'(b);
        for (int k = 0; k < n; k++) begin
            if (((va >> ((n - 1 - k) * s)) & m) != ((vb >> ((n - 1 - k) * s)) & m)) return k + 1;
        end
        return n;
    endfunction

    task automatic runCompare(input logic [15:0] a, input logic [15:0] b, input logic sg,
                              input int glitchAt);
        @(negedge clk);
        opA = a; opB = b; sgn = sg; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        opA = 16'($urandom); opB = 16'($urandom); sgn = 1'($urandom_range(0, 1));
        busyCnt = bsy[0] ? 1 : 0;
        chgCnt = 0;
        for (int i = 0; i < NDUT; i++) begin
            lat[i] = 0; dnCnt[i] = 0; fl[i] = 3'b000; prevFl[i] = flagsOf(i);
        end
        for (int c = 1; c <= WINDOW; c++) begin
            start = (c == glitchAt);
            if (start) begin
                opA = 16'($urandom); opB = 16'($urandom);
            end
            @(posedge clk); #1;
            for (int i = 0; i < NDUT; i++) begin
                if (dn[i]) begin
                    dnCnt[i]++;
                    if (lat[i] == 0) begin
                        lat[i] = c;
                        fl[i] = flagsOf(i);
                    end
                end
                if (bsy[i] && flagsOf(i) !== prevFl[i]) chgCnt++;
                prevFl[i] = flagsOf(i);
            end
            if (bsy[0]) busyCnt++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if ({bsy[i], dn[i], flagsOf(i)} !== 5'b0) begin
                errors++;
                $display("FAIL reset_in dut%0d: got %b required 00000", i, {bsy[i], dn[i], flagsOf(i)});
            end
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if ({bsy[i], dn[i], flagsOf(i)} !== 5'b0) begin
                errors++;
                $display("FAIL reset_idle dut%0d: got %b required 00000", i, {bsy[i], dn[i], flagsOf(i)});
            end
        end
    endtask

    task automatic test_equal;
        runCompare(16'h5A5A, 16'h5A5A, 1'b0, 0);
        checks++;
        if (lat[0] !== 8 || fl[0] !== 3'b100) begin
            errors++;
            $display("FAIL equal: lat %0d flags %b required lat 8 flags 100", lat[0], fl[0]);
        end
        checks++;
        if (busyCnt !== 8) begin
            errors++;
            $display("FAIL equal_busy: busy cycles %0d required 8", busyCnt);
        end
        checks++;
        if (dnCnt[0] !== 1) begin
            errors++;
            $display("FAIL equal_done_width: done cycles %0d required 1", dnCnt[0]);
        end
    endtask

    task automatic test_signed;
        runCompare(16'h0080, 16'h007F, 1'b0, 0);
        checks++;
        if (lat[0] !== 1 || fl[0] !== 3'b010) begin
            errors++;
            $display("FAIL unsigned_msb: lat %0d flags %b required lat 1 flags 010", lat[0], fl[0]);
        end
        runCompare(16'h0080, 16'h007F, 1'b1, 0);
        checks++;
        if (lat[0] !== 1 || fl[0] !== 3'b001) begin
            errors++;
            $display("FAIL signed_msb: lat %0d flags %b required lat 1 flags 001", lat[0], fl[0]);
        end
    endtask

    task automatic test_low_slice;
        runCompare(16'h00F0, 16'h00F1, 1'b0, 0);
        checks++;
        if (lat[0] !== 8 || fl[0] !== 3'b001) begin
            errors++;
            $display("FAIL lsb_diff: lat %0d flags %b required lat 8 flags 001", lat[0], fl[0]);
        end
        runCompare(16'h0001, 16'h0000, 1'b0, 0);
        checks++;
        if (lat[1] !== 8 || fl[1] !== 3'b010) begin
            errors++;
            $display("FAIL no_early_exit: lat %0d flags %b required lat 8 flags 010", lat[1], fl[1]);
        end
        runCompare(16'h0080, 16'h0001, 1'b0, 0);
        checks++;
        if (lat[1] !== 8 || fl[1] !== 3'b010) begin
            errors++;
            $display("FAIL sticky_first_diff: lat %0d flags %b required lat 8 flags 010", lat[1], fl[1]);
        end
    endtask

    task automatic test_wide;
        runCompare(16'hFFFE, 16'hFFFF, 1'b1, 0);
        checks++;
        if (lat[2] !== 4 || fl[2] !== 3'b001) begin
            errors++;
            $display("FAIL wide_signed: lat %0d flags %b required lat 4 flags 001", lat[2], fl[2]);
        end
    endtask

    task automatic test_mid_run_start;
        runCompare(16'h5A5A, 16'h5A5A, 1'b0, 3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (lat[i] !== 8 || fl[i] !== 3'b100 || dnCnt[i] !== 1) begin
                errors++;
                $display("FAIL mid_run_start dut%0d: lat %0d flags %b dones %0d required 8 100 1",
                         i, lat[i], fl[i], dnCnt[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int dones, acceptC, secondLat;
        logic [2:0] firstFl, secondFl;
        dones = 0; acceptC = 0; secondLat = 0; firstFl = '0; secondFl = '0;
        @(negedge clk);
        opA = 16'h0080; opB = 16'h007F; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (dn[0]) begin
                dones++;
                if (dones == 1) begin
                    firstFl = flagsOf(0);
                    start = 1'b1; opA = 16'h0001; opB = 16'h0002; acceptC = c + 1;
                end else if (dones == 2) begin
                    secondFl = flagsOf(0);
                    secondLat = c - acceptC;
                end
            end
        end
        checks++;
        if (dones !== 2) begin
            errors++;
            $display("FAIL b2b_dones: got %0d required 2", dones);
        end
        checks++;
        if (firstFl !== refFlags(16'h80, 16'h7F, 8, 1'b0)) begin
            errors++;
            $display("FAIL b2b_first: flags %b required 010", firstFl);
        end
        checks++;
        if (secondFl !== refFlags(16'h01, 16'h02, 8, 1'b0) ||
            secondLat !== refLat(16'h01, 16'h02, 8, 1, 1)) begin
            errors++;
            $display("FAIL b2b_second: flags %b lat %0d required 001 lat 7", secondFl, secondLat);
        end
    endtask

    task automatic test_reset_abort;
        int stray;
        stray = 0;
        @(negedge clk);
        opA = 16'h5A5A; opB = 16'h5A5A; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bsy[0], dn[0], flagsOf(0)} !== 5'b0 || {bsy[2], flagsOf(2)} !== 4'b0) begin
            errors++;
            $display("FAIL abort_async: got %b required 00000", {bsy[0], dn[0], flagsOf(0)});
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NDUT; i++) if (dn[i] || bsy[i]) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL abort_no_done: stray busy/done samples %0d required 0", stray);
        end
        runCompare(16'h00F0, 16'h00F1, 1'b0, 0);
        checks++;
        if (lat[0] !== 8 || fl[0] !== 3'b001) begin
            errors++;
            $display("FAIL after_abort: lat %0d flags %b required lat 8 flags 001", lat[0], fl[0]);
        end
    endtask

    task automatic test_random;
        logic [15:0] a, b;
        logic sg;
        int mode;
        for (int n = 0; n < 200; n++) begin
            mode = $urandom_range(0, 2);
            a = 16'($urandom);
            sg = 1'($urandom_range(0, 1));
            case (mode)
                1: b = a;
                2: b = a ^ (16'h1 << $urandom_range(0, 15));
                default: b = 16'($urandom);
            endcase
            runCompare(a, b, sg, 0);
            for (int i = 0; i < NDUT; i++) begin
                checks++;
                if (fl[i] !== refFlags(a, b, PW[i], sg) || lat[i] !== refLat(a, b, PW[i], PS[i], PE[i])
                    || dnCnt[i] !== 1) begin
                    errors++;
                    $display("FAIL random dut%0d a=%h b=%h s=%0d: flags %b lat %0d dones %0d required %b %0d 1",
                             i, a, b, sg, fl[i], lat[i], dnCnt[i], refFlags(a, b, PW[i], sg),
                             refLat(a, b, PW[i], PS[i], PE[i]));
                end
            end
            checks++;
            if (chgCnt !== 0) begin
                errors++;
                $display("FAIL random_hold a=%h b=%h: flag changes while busy %0d required 0", a, b, chgCnt);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        test_reset;
        test_equal;
        test_signed;
        test_low_slice;
        test_wide;
        test_mid_run_start;
        test_back_to_back;
        test_reset_abort;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
